multi_sfx_audio: RTL and testbench

MULTI_SFX_AUDIO -- requirements
Module: multi_sfx_audio

---
 rtl/multi_sfx_audio_pkg.sv | 13 +
 rtl/multi_sfx_audio_channel.sv | 131 +++++++++++++
 rtl/multi_sfx_audio.sv | 54 +++++
 tb/tb_multi_sfx_audio.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_sfx_audio_pkg.sv
// Shared types and default widths for the
// multi-channel sound-effect player.
package multi_sfx_audio_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } ch_state_e;

endpackage

// File: rtl/multi_sfx_audio_channel.sv
// One sound-effect channel: rate divider,
// sample handshake and clip address walker.
module sfx_channel
  import multi_sfx_audio_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              init_done,
  input  logic              sample_req,
  input  logic              trig,
  input  logic              loop_en,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] ch_addr,
  output logic              ch_active,
  output logic              ch_done
);

  ch_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              loop_q, loop_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;

  logic start, tick, req, adv, last;

  assign start = trig & init_done & (length != '0);
  assign tick  = (cnt_q == div_q);
  assign req   = pend_q | tick;
  assign adv   = req & sample_req;
  assign last  = (off_q == len_q - ADDR_W'(1));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: drop-out, retrigger, then end of clip
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = PLAY;
      PLAY: begin
        if (!init_done)                  state_d = IDLE;
        else if (start)                  state_d = PLAY;
        else if (adv && last && !loop_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; a retrigger wins over advance
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    div_d  = div_q;
    loop_d = loop_q;
    off_d  = off_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    done_d = 1'b0;
    if (state_q == IDLE || !init_done || start) begin
      off_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
      if (start) begin
        base_d = base_addr;
        len_d  = length;
        div_d  = rate_div;
        loop_d = loop_en;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
      if (adv) begin
        pend_d = 1'b0;
        if (last) begin
          off_d  = '0;
          done_d = !loop_q;
        end else begin
          off_d = off_q + ADDR_W'(1);
        end
      end else begin
        pend_d = req;
      end
    end
    addr_d = (state_d == PLAY) ? base_d + off_d : '0;
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      base_q <= '0;
      len_q  <= '0;
      div_q  <= '0;
      loop_q <= 1'b0;
      off_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      div_q  <= div_d;
      loop_q <= loop_d;
      off_q  <= off_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      done_q <= done_d;
      addr_q <= addr_d;
    end
  end

  // Outputs straight from registers
  always_comb begin
    ch_active = (state_q == PLAY);
    ch_addr   = addr_q;
    ch_done   = done_q;
  end

endmodule

// File: rtl/multi_sfx_audio.sv
// Multi-channel sound-effect player top:
// bus slicing plus codec init request.
module multi_sfx_audio
  import multi_sfx_audio_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     init_done,
  input  logic                     sample_req,
  input  logic [NUM_CH-1:0]        trig,
  input  logic [NUM_CH-1:0]        loop_en,
  input  logic [NUM_CH*DIV_W-1:0]  rate_div,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH*ADDR_W-1:0] length,
  output logic                     init_req,
  output logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_active,
  output logic [NUM_CH-1:0]        ch_done
);

  logic init_q;

  // Request codec init from the first cycle out of reset
  always_ff @(posedge Clk) begin
    init_q <= !Reset;
  end

  assign init_req = init_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sfx_channel #(
      .ADDR_W(ADDR_W),
      .DIV_W (DIV_W)
    ) u_ch (
      .Clk       (Clk),
      .Reset     (Reset),
      .init_done (init_done),
      .sample_req(sample_req),
      .trig      (trig[g]),
      .loop_en   (loop_en[g]),
      .rate_div  (rate_div[g*DIV_W +: DIV_W]),
      .base_addr (base_addr[g*ADDR_W +: ADDR_W]),
      .length    (length[g*ADDR_W +: ADDR_W]),
      .ch_addr   (ch_addr[g*ADDR_W +: ADDR_W]),
      .ch_active (ch_active[g]),
      .ch_done   (ch_done[g])
    );
  end

endmodule

// File: tb/tb_multi_sfx_audio.sv
// Directed scoreboard bench for multi_sfx_audio:
// expected addresses queued, observed changes popped.
module tb_multi_sfx_audio;

  localparam int N  = 4;
  localparam int AW = 17;
  localparam int DW = 16;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            init_done;
  logic            sample_req;
  logic [N-1:0]    trig;
  logic [N-1:0]    loop_en;
  logic [N*DW-1:0] rate_div;
  logic [N*AW-1:0] base_addr;
  logic [N*AW-1:0] length;
  logic            init_req;
  logic [N*AW-1:0] ch_addr;
  logic [N-1:0]    ch_active;
  logic [N-1:0]    ch_done;

  multi_sfx_audio #(.NUM_CH(N), .ADDR_W(AW), .DIV_W(DW)) dut (
    .Clk(Clk), .Reset(Reset), .init_done(init_done),
    .sample_req(sample_req), .trig(trig), .loop_en(loop_en),
    .rate_div(rate_div), .base_addr(base_addr), .length(length),
    .init_req(init_req), .ch_addr(ch_addr),
    .ch_active(ch_active), .ch_done(ch_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
    logic          done;
    logic          act;
  } obs_t;

  obs_t          obs_q[$];
  logic [AW-1:0] exp_q[$];
  logic [N*AW-1:0] prev_addr = '0;
  logic [N-1:0]  watch = '0;
  int            done_cnt[N];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  int            ob_cyc[16];
  logic          ob_done[16];
  logic          ob_act[16];
  int            d0, d1, dsum;

  function automatic logic [AW-1:0] a_of(input int c);
    return ch_addr[c*AW +: AW];
  endfunction

  // Record address changes on watched channels and count done pulses
  always @(posedge Clk) begin
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (watch[i] && (ch_addr[i*AW +: AW] != prev_addr[i*AW +: AW])) begin
        obs_t o;
        o.addr = ch_addr[i*AW +: AW];
        o.cyc  = cyc;
        o.done = ch_done[i];
        o.act  = ch_active[i];
        obs_q.push_back(o);
      end
      if (ch_done[i] === 1'b1) done_cnt[i]++;
    end
    prev_addr = ch_addr;
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_n(input string tag, input int n, input int budget);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      logic [AW-1:0] e = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      while (obs_q.size() == 0 && w < budget) begin
        @(negedge Clk);
        w++;
      end
      if (obs_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL %s[%0d] timeout observed=none expected=%0h", tag, k, e);
      end else begin
        obs_t o = obs_q.pop_front();
        ob_cyc[k]  = o.cyc;
        ob_done[k] = o.done;
        ob_act[k]  = o.act;
        chk($sformatf("%s[%0d]", tag, k), 32'(o.addr), 32'(e));
      end
    end
  endtask

  task automatic set_ch(input int c, input logic [AW-1:0] b,
                        input logic [AW-1:0] l, input logic [DW-1:0] d,
                        input logic lp);
    base_addr[c*AW +: AW] = b;
    length[c*AW +: AW]    = l;
    rate_div[c*DW +: DW]  = d;
    loop_en[c]            = lp;
  endtask

  task automatic pulse_trig(input logic [N-1:0] m);
    @(negedge Clk);
    trig = m;
    @(negedge Clk);
    trig = '0;
  endtask

  task automatic arm(input logic [N-1:0] m);
    watch = m;
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    Reset      = 1'b1;
    init_done  = 1'b1;
    sample_req = 1'b0;
    trig       = '1;
    loop_en    = '0;
    rate_div   = '0;
    base_addr  = '0;
    length     = '0;
    for (int i = 0; i < N; i++) set_ch(i, 17'h10 * i, 17'd4, 16'd1, 1'b0);

    // Reset holds everything idle even with triggers
    repeat (3) @(negedge Clk);
    chk("rst_init_req", 32'(init_req), 0);
    chk("rst_active", 32'(ch_active), 0);
    chk("rst_done", 32'(ch_done), 0);
    chk("rst_addr", 32'(ch_addr != '0), 0);
    Reset = 1'b0;
    trig  = '0;
    init_done = 1'b0;
    @(negedge Clk);
    chk("init_req_up", 32'(init_req), 1);

    // Trigger without codec init is ignored
    pulse_trig(4'b0001);
    @(negedge Clk);
    chk("noinit_active", 32'(ch_active), 0);
    chk("noinit_addr", 32'(a_of(0)), 0);
    init_done = 1'b1;

    // One-shot clip, sample_req held
    sample_req = 1'b1;
    set_ch(0, 17'h100, 17'd3, 16'd2, 1'b0);
    arm(4'b0001);
    exp_q = '{17'h100, 17'h101, 17'h102, 17'h0};
    d0 = done_cnt[0];
    pulse_trig(4'b0001);
    check_n("oneshot", 4, 20);
    chk("oneshot_gap1", ob_cyc[1] - ob_cyc[0], 3);
    chk("oneshot_gap2", ob_cyc[2] - ob_cyc[1], 3);
    chk("oneshot_gap3", ob_cyc[3] - ob_cyc[2], 3);
    chk("oneshot_end_done", 32'(ob_done[3]), 1);
    chk("oneshot_end_act", 32'(ob_act[3]), 0);
    repeat (4) @(negedge Clk);
    chk("oneshot_done_cnt", done_cnt[0] - d0, 1);

    // Looping clip never ends
    set_ch(0, 17'h100, 17'd3, 16'd2, 1'b1);
    arm(4'b0001);
    exp_q = '{17'h100, 17'h101, 17'h102, 17'h100,
              17'h101, 17'h102, 17'h100};
    d0 = done_cnt[0];
    pulse_trig(4'b0001);
    check_n("loop", 7, 20);
    chk("loop_wrap_gap", ob_cyc[6] - ob_cyc[5], 3);
    chk("loop_no_done", done_cnt[0] - d0, 0);

    // Fast ticks, sparse sample_req: one advance per request
    @(negedge Clk);
    sample_req = 1'b0;
    set_ch(2, 17'h20, 17'd8, 16'd0, 1'b0);
    arm(4'b0100);
    exp_q = '{17'h20, 17'h21, 17'h22, 17'h23};
    pulse_trig(4'b0100);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      sample_req = 1'b1;
      @(negedge Clk);
      sample_req = 1'b0;
      repeat (3) @(negedge Clk);
    end
    check_n("sparse", 4, 20);
    chk("sparse_gap1", ob_cyc[2] - ob_cyc[1], 5);
    chk("sparse_gap2", ob_cyc[3] - ob_cyc[2], 5);
    repeat (5) @(negedge Clk);
    chk("sparse_no_extra", obs_q.size(), 0);
    chk("sparse_hold", 32'(a_of(2)), 32'h23);
    sample_req = 1'b1;

    // Retrigger mid-clip with a base that wraps the address space
    set_ch(1, 17'h40, 17'd8, 16'd1, 1'b0);
    arm(4'b0010);
    exp_q = '{17'h40, 17'h41, 17'h42};
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    pulse_trig(4'b0010);
    check_n("pre_retrig", 3, 20);
    chk("retrig_at_off2", 32'(a_of(1)), 32'h42);
    set_ch(1, 17'h1FFFF, 17'd4, 16'd1, 1'b0);
    exp_q = '{17'h1FFFF, 17'h0, 17'h1, 17'h2, 17'h0};
    pulse_trig(4'b0010);
    check_n("retrig", 5, 20);
    chk("retrig_no_done", 32'(ob_done[0]), 0);
    chk("retrig_end_done", 32'(ob_done[4]), 1);
    chk("retrig_end_act", 32'(ob_act[4]), 0);
    chk("retrig_done_cnt", done_cnt[1] - d1, 1);
    chk("ch0_still_active", 32'(ch_active[0]), 1);
    chk("ch0_no_done", done_cnt[0] - d0, 0);

    // All channels playing, then Reset aborts them silently
    arm('0);
    set_ch(0, 17'h100, 17'd3, 16'd2, 1'b0);
    set_ch(1, 17'h200, 17'd6, 16'd1, 1'b0);
    set_ch(2, 17'h20, 17'd8, 16'd0, 1'b0);
    set_ch(3, 17'h300, 17'd5, 16'd3, 1'b1);
    pulse_trig(4'hF);
    chk("all_active", 32'(ch_active), 32'hF);
    dsum = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
    Reset = 1'b1;
    trig  = 4'hF;
    @(negedge Clk);
    chk("abort_active", 32'(ch_active), 0);
    chk("abort_done", 32'(ch_done), 0);
    chk("abort_addr", 32'(ch_addr != '0), 0);
    chk("abort_init_req", 32'(init_req), 0);
    Reset = 1'b0;
    trig  = '0;
    repeat (2) @(negedge Clk);
    chk("abort_no_done",
        done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3] - dsum, 0);

    // Zero-length trigger is ignored
    set_ch(3, 17'h300, 17'd0, 16'd0, 1'b0);
    pulse_trig(4'b1000);
    @(negedge Clk);
    chk("len0_active", 32'(ch_active), 0);
    chk("len0_addr", 32'(a_of(3)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
